// File: rtl/dffs_sp_arbiter.sv
// Round-robin arbiter and zero-fill clear sequencer in front of one single-port
// DFF memory (active-low CEN/WEN, read data valid the cycle after access).
module dffs_sp_arbiter #(
    parameter int unsigned SIZE = 4,
    parameter int unsigned WLEN = 32,
    parameter int unsigned NREQ = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        REQ_VLD,
    input  logic [NREQ-1:0]        REQ_WE,
    input  logic [NREQ*SIZE-1:0]   REQ_A,
    input  logic [NREQ*WLEN-1:0]   REQ_D,
    output logic [NREQ-1:0]        REQ_RDY,
    output logic [NREQ-1:0]        RSP_VLD,
    output logic [WLEN-1:0]        RSP_Q,
    input  logic                   CLR,
    output logic                   BUSY,
    output logic                   CEN,
    output logic                   WEN,
    output logic [SIZE-1:0]        A,
    output logic [WLEN-1:0]        D,
    input  logic [WLEN-1:0]        Q
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam logic [SIZE-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    pri_q, pri_d;
    logic [SIZE-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   rsel_q, rsel_d;

    logic              found;
    int unsigned       gi;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        found = 1'b0;
        gi    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned idx;
            idx = (32'(pri_q) + k) % NREQ;
            if (!found && REQ_VLD[idx]) begin
                found = 1'b1;
                gi    = idx;
            end
        end
    end

    // Next-state and memory-side outputs.
    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        cnt_d   = cnt_q;
        rsel_d  = '0;
        REQ_RDY = '0;
        CEN     = 1'b1;
        WEN     = 1'b1;
        A       = '0;
        D       = '0;

        if (!RST) begin
            case (state_q)
                IDLE: begin
                    if (CLR) begin
                        state_d = CLEAR;
                    end else if (found) begin
                        REQ_RDY    = NREQ'(1) << gi;
                        CEN        = 1'b0;
                        WEN        = ~REQ_WE[gi];
                        A          = REQ_A[gi*SIZE +: SIZE];
                        D          = REQ_D[gi*WLEN +: WLEN];
                        pri_d      = IDW'((gi + 1) % NREQ);
                        rsel_d[gi] = ~REQ_WE[gi];
                    end
                end
                CLEAR: begin
                    CEN   = 1'b0;
                    WEN   = 1'b0;
                    A     = cnt_q;
                    cnt_d = cnt_q + SIZE'(1);
                    if (cnt_q == CNT_MAX) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pri_q   <= '0;
            cnt_q   <= '0;
            rsel_q  <= '0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            cnt_q   <= cnt_d;
            rsel_q  <= rsel_d;
        end
    end

    assign RSP_VLD = rsel_q;
    assign RSP_Q   = Q;
    assign BUSY    = (state_q == CLEAR);

endmodule
